// File: rtl/best_match_select_pkg.sv
// Shared constants and state encoding for the nearest-neighbour selection path.
// Used by the distance units, best_match_select and the keypoint-matching controller.
package best_match_select_pkg;

  localparam int DIST_W    = 14;
  localparam int IDX_W     = 10;
  localparam int RATIO_NUM = 4;
  localparam int RATIO_DEN = 5;

  // Product width for the ratio test; 3 guard bits cover constants up to 7.
  localparam int PROD_W = DIST_W + 3;

  localparam logic [DIST_W-1:0] DIST_MAX = {DIST_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_RATIO = 2'd2,
    S_DONE  = 2'd3
  } bms_state_t;

endpackage

// File: rtl/best_match_select_if.sv
// Candidate stream in, match result out, between distance units and match controller.
// master = the side that feeds candidates and consumes results; slave = best_match_select.
interface best_match_select_if;
  import best_match_select_pkg::*;

  logic              start;
  logic              dist_valid;
  logic              dist_ready;
  logic [DIST_W-1:0] dist_in;
  logic [IDX_W-1:0]  dist_idx;
  logic              dist_last;
  logic              match_valid;
  logic              match_ready;
  logic [IDX_W-1:0]  match_idx;
  logic [DIST_W-1:0] match_dist;
  logic [DIST_W-1:0] second_dist;
  logic              match_ok;

  modport master (
    output start, dist_valid, dist_in, dist_idx, dist_last, match_ready,
    input  dist_ready, match_valid, match_idx, match_dist, second_dist, match_ok
  );

  modport slave (
    input  start, dist_valid, dist_in, dist_idx, dist_last, match_ready,
    output dist_ready, match_valid, match_idx, match_dist, second_dist, match_ok
  );

endinterface

// File: rtl/best_match_select_top2_tracker.sv
// Tracks smallest and second-smallest distance seen plus the index of the smallest.
// Latency: one cycle from accepted candidate to updated registers.
// Backpressure: none; updates only when the parent qualifies a candidate with i_upd.
module top2_tracker
  import best_match_select_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_upd,
  input  logic [DIST_W-1:0] i_dist,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DIST_W-1:0] o_best,
  output logic [DIST_W-1:0] o_second,
  output logic [IDX_W-1:0]  o_best_idx
);

  logic [DIST_W-1:0] r_best;
  logic [DIST_W-1:0] r_second;
  logic [IDX_W-1:0]  r_best_idx;

  // Clear to the ceiling at query start, otherwise insert accepted candidates;
  // a tie with best falls through to second so equal-best queries fail the ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best     <= DIST_MAX;
      r_second   <= DIST_MAX;
      r_best_idx <= '0;
    end else if (i_clear) begin
      r_best     <= DIST_MAX;
      r_second   <= DIST_MAX;
      r_best_idx <= '0;
    end else if (i_upd) begin
      if (i_dist < r_best) begin
        r_second   <= r_best;
        r_best     <= i_dist;
        r_best_idx <= i_idx;
      end else if (i_dist < r_second) begin
        r_second <= i_dist;
      end
    end
  end

  assign o_best     = r_best;
  assign o_second   = r_second;
  assign o_best_idx = r_best_idx;

endmodule

// File: rtl/best_match_select.sv
// Per-query nearest-neighbour selector with Lowe ratio test on best vs second-best.
// Latency: last candidate accepted at t -> match_valid at t+2; one candidate per cycle in SCAN.
// Backpressure: result held stable until match_ready; no candidates accepted outside SCAN.
module best_match_select
  import best_match_select_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  best_match_select_if.slave   bus
);

  bms_state_t        r_state;
  logic              r_dist_rdy;
  logic              r_match_vld;
  logic              r_match_ok;

  logic              w_accept;
  logic              w_clear;
  logic [DIST_W-1:0] w_best;
  logic [DIST_W-1:0] w_second;
  logic [IDX_W-1:0]  w_best_idx;
  logic [PROD_W-1:0] w_lhs;
  logic [PROD_W-1:0] w_rhs;

  assign w_accept = bus.dist_valid && r_dist_rdy;
  assign w_clear  = (r_state == S_IDLE) && bus.start;

  // Ratio test operands, widened so neither product can wrap.
  assign w_lhs = PROD_W'(w_best)   * PROD_W'(RATIO_DEN);
  assign w_rhs = PROD_W'(w_second) * PROD_W'(RATIO_NUM);

  top2_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_upd      (w_accept),
    .i_dist     (bus.dist_in),
    .i_idx      (bus.dist_idx),
    .o_best     (w_best),
    .o_second   (w_second),
    .o_best_idx (w_best_idx)
  );

  // Query sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dist_rdy  <= 1'b0;
      r_match_vld <= 1'b0;
      r_match_ok  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_SCAN;
            r_dist_rdy <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_accept && bus.dist_last) begin
            r_state    <= S_RATIO;
            r_dist_rdy <= 1'b0;
          end
        end
        S_RATIO: begin
          r_match_ok  <= (w_lhs < w_rhs);
          r_match_vld <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.match_ready) begin
            r_match_vld <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_dist_rdy  <= 1'b0;
          r_match_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dist_ready  = r_dist_rdy;
  assign bus.match_valid = r_match_vld;
  assign bus.match_ok    = r_match_ok;
  assign bus.match_idx   = w_best_idx;
  assign bus.match_dist  = w_best;
  assign bus.second_dist = w_second;

endmodule

// File: tb/tb_best_match_select.sv
// Directed self-checking bench for best_match_select.
// Table of complete queries plus hand-written backpressure and reset-abort sequences.
module tb_best_match_select;
  import best_match_select_pkg::*;

  logic clk;
  logic rst_n;

  best_match_select_if bmi ();

  best_match_select dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int                     n;
    logic [3:0][DIST_W-1:0] d;
    int                     base;
    logic [IDX_W-1:0]       e_idx;
    logic [DIST_W-1:0]      e_best;
    logic [DIST_W-1:0]      e_sec;
    logic                   e_ok;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; leaves the block sitting in DONE.
  task automatic stream_query(input vec_t v, input string tag);
    bmi.start = 1'b1;
    @(posedge clk); #1;
    bmi.start = 1'b0;
    chk({tag, " ready after start"}, 32'(bmi.dist_ready), 32'd1);
    for (int k = 0; k < v.n; k++) begin
      bmi.dist_valid = 1'b1;
      bmi.dist_in    = v.d[k];
      bmi.dist_idx   = IDX_W'(v.base + k);
      bmi.dist_last  = (k == v.n - 1);
      @(posedge clk); #1;
    end
    bmi.dist_valid = 1'b0;
    bmi.dist_last  = 1'b0;
    chk({tag, " valid low in ratio"}, 32'(bmi.match_valid), 32'd0);
    chk({tag, " ready low in ratio"}, 32'(bmi.dist_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, " valid at last+2"}, 32'(bmi.match_valid), 32'd1);
    chk({tag, " match_idx"},   32'(bmi.match_idx),   32'(v.e_idx));
    chk({tag, " match_dist"},  32'(bmi.match_dist),  32'(v.e_best));
    chk({tag, " second_dist"}, 32'(bmi.second_dist), 32'(v.e_sec));
    chk({tag, " match_ok"},    32'(bmi.match_ok),    32'(v.e_ok));
  endtask

  task automatic release_result(input string tag);
    bmi.match_ready = 1'b1;
    @(posedge clk); #1;
    bmi.match_ready = 1'b0;
    chk({tag, " valid drops after handshake"}, 32'(bmi.match_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dist_ready"},  32'(bmi.dist_ready),  32'd0);
    chk({tag, " match_valid"}, 32'(bmi.match_valid), 32'd0);
    chk({tag, " match_ok"},    32'(bmi.match_ok),    32'd0);
    chk({tag, " match_idx"},   32'(bmi.match_idx),   32'd0);
    chk({tag, " match_dist"},  32'(bmi.match_dist),  32'd16383);
    chk({tag, " second_dist"}, 32'(bmi.second_dist), 32'd16383);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [IDX_W-1:0]  h_idx;
    logic [DIST_W-1:0] h_best;
    logic [DIST_W-1:0] h_sec;
    logic              h_ok;

    // n, distances (element 0 first), base index, exp idx, best, second, ok
    vecs[0] = '{4, {14'd130, 14'd450, 14'd120, 14'd300}, 0,   10'd1,   14'd120, 14'd130,   1'b0};
    vecs[1] = '{3, {14'd0,   14'd400, 14'd100, 14'd500}, 0,   10'd1,   14'd100, 14'd400,   1'b1};
    vecs[2] = '{2, {14'd0,   14'd0,   14'd200, 14'd200}, 0,   10'd0,   14'd200, 14'd200,   1'b0};
    vecs[3] = '{1, {14'd0,   14'd0,   14'd0,   14'd50 }, 0,   10'd0,   14'd50,  14'd16383, 1'b1};
    vecs[4] = '{4, {14'd10,  14'd20,  14'd30,  14'd40 }, 100, 10'd103, 14'd10,  14'd20,    1'b1};

    rst_n           = 1'b0;
    bmi.start       = 1'b0;
    bmi.dist_valid  = 1'b0;
    bmi.dist_in     = '0;
    bmi.dist_idx    = '0;
    bmi.dist_last   = 1'b0;
    bmi.match_ready = 1'b0;

    #22;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Candidate offered in IDLE must not be taken or disturb the next query.
    bmi.dist_valid = 1'b1;
    bmi.dist_in    = 14'd3;
    bmi.dist_idx   = 10'd7;
    bmi.dist_last  = 1'b1;
    @(posedge clk); #1;
    chk("idle ready low", 32'(bmi.dist_ready), 32'd0);
    chk("idle no result", 32'(bmi.match_valid), 32'd0);
    bmi.dist_valid = 1'b0;
    bmi.dist_last  = 1'b0;

    for (int i = 0; i < 5; i++) begin
      stream_query(vecs[i], $sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held 10 cycles while start and candidates are thrown at it.
    stream_query(vecs[1], "bp");
    for (int c = 0; c < 10; c++) begin
      bmi.start      = c[0];
      bmi.dist_valid = 1'b1;
      bmi.dist_in    = 14'd1;
      bmi.dist_idx   = 10'd9;
      bmi.dist_last  = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp valid c%0d", c), 32'(bmi.match_valid), 32'd1);
      chk($sformatf("bp ready c%0d", c), 32'(bmi.dist_ready), 32'd0);
      chk($sformatf("bp idx c%0d", c),   32'(bmi.match_idx),   32'd1);
      chk($sformatf("bp dist c%0d", c),  32'(bmi.match_dist),  32'd100);
      chk($sformatf("bp sec c%0d", c),   32'(bmi.second_dist), 32'd400);
      chk($sformatf("bp ok c%0d", c),    32'(bmi.match_ok),    32'd1);
    end
    bmi.start      = 1'b0;
    bmi.dist_valid = 1'b0;
    bmi.dist_last  = 1'b0;
    release_result("bp");
    chk("bp idle ready low", 32'(bmi.dist_ready), 32'd0);
    // Start on the cycle right after the handshake must be honoured.
    bmi.start = 1'b1;
    @(posedge clk); #1;
    bmi.start = 1'b0;
    chk("bp restart ready", 32'(bmi.dist_ready), 32'd1);
    bmi.dist_valid = 1'b1;
    bmi.dist_in    = 14'd1000;
    bmi.dist_idx   = 10'd4;
    bmi.dist_last  = 1'b1;
    @(posedge clk); #1;
    bmi.dist_valid = 1'b0;
    bmi.dist_last  = 1'b0;
    @(posedge clk); #1;
    chk("bp restart valid", 32'(bmi.match_valid), 32'd1);
    chk("bp restart idx",   32'(bmi.match_idx),   32'd4);
    chk("bp restart ok",    32'(bmi.match_ok),    32'd1);
    release_result("bp restart");

    // Reset mid-SCAN after 5 small candidates; nothing may survive.
    bmi.start = 1'b1;
    @(posedge clk); #1;
    bmi.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bmi.dist_valid = 1'b1;
      bmi.dist_in    = 14'(5 + k);
      bmi.dist_idx   = 10'(20 + k);
      bmi.dist_last  = 1'b0;
      @(posedge clk); #1;
    end
    bmi.dist_valid = 1'b0;
    chk("abort mid scan best", 32'(bmi.match_dist), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); #1;
    chk("abort held no result", 32'(bmi.match_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    v.n    = 2;
    v.d    = {14'd0, 14'd0, 14'd10, 14'd700};
    v.base = 0;
    h_idx  = 10'd1;
    h_best = 14'd10;
    h_sec  = 14'd700;
    h_ok   = 1'b1;
    v.e_idx  = h_idx;
    v.e_best = h_best;
    v.e_sec  = h_sec;
    v.e_ok   = h_ok;
    stream_query(v, "post-abort");
    release_result("post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/best_match_select.md
# best_match_select

Streaming nearest-neighbour selector that sits directly downstream of the 32-dimension L1 distance units. For one query descriptor it consumes a stream of 14-bit candidate distances tagged with candidate indices and tracks the smallest and second-smallest distance. At end of stream it applies a Lowe-style ratio test and presents one match result through a valid/ready handshake to the keypoint-matching controller.

## Interface
- DIST_W, 14, candidate distance width; matches the distance unit output.
- IDX_W, 10, candidate index width (up to 1024 candidates per query).
- RATIO_NUM, 4, ratio-test numerator.
- RATIO_DEN, 5, ratio-test denominator. Match accepted iff best*RATIO_DEN < second*RATIO_NUM.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin new query; honoured only in IDLE.
- dist_valid  in  1  candidate distance present.
- dist_ready  out  1  block accepts a candidate this cycle.
- dist_in  in  DIST_W  candidate distance.
- dist_idx  in  IDX_W  candidate index.
- dist_last  in  1  marks final candidate of the query.
- match_valid  out  1  result present.
- match_ready  in  1  consumer takes result.
- match_idx  out  IDX_W  index of best candidate.
- match_dist  out  DIST_W  best distance.
- second_dist  out  DIST_W  second-best distance.
- match_ok  out  1  ratio test passed.

## Operation
- States: IDLE, SCAN, RATIO, DONE.
- IDLE: dist_ready=0, match_valid=0. start=1 -> SCAN; best and second loaded with all-ones (2^DIST_W-1), match_idx cleared to 0.
- SCAN: dist_ready=1. Accept on dist_valid&&dist_ready. Update for accepted d with index i:
  - d < best: second<=best; best<=d; best_idx<=i.
  - else d < second: second<=d.
  - else no change. Tie with best goes to second (d==best -> second<=d), so equal-best queries fail the ratio test.
- Accepted candidate with dist_last=1 is processed, then SCAN -> RATIO.
- RATIO: dist_ready=0. Compute best*RATIO_DEN and second*RATIO_NUM at DIST_W+3 bits each (no overflow for constants ≤7); register match_ok = strict less-than. -> DONE.
- DONE: match_valid=1, outputs stable. match_valid&&match_ready -> IDLE.
- Single-candidate query: second stays all-ones; match_ok by arithmetic (passes unless best is near the ceiling).
- start outside IDLE ignored. dist_valid outside SCAN ignored (dist_ready=0, no state change).

## Timing
- Reset (async assert, sync-safe release): state IDLE; dist_ready=0, match_valid=0, match_ok=0, match_idx=0, match_dist=all-ones, second_dist=all-ones.
- Reset mid-SCAN or mid-DONE discards the query; no partial result emitted.
- start sampled at cycle t -> dist_ready=1 at t+1.
- Throughput in SCAN: one candidate per cycle, no bubbles.
- Last candidate accepted at cycle t -> RATIO at t+1 -> match_valid=1 at t+2.
- match_valid held with stable outputs until handshake; handshake at cycle u -> match_valid=0 and IDLE at u+1. start can be accepted at u+1 earliest.
- Minimum query period: N candidates + 3 cycles plus start cycle.

## Structure
- Shared package: DIST_W, IDX_W defaults, DIST_MAX all-ones constant, state encoding enum (IDLE/SCAN/RATIO/DONE), shared with the distance unit and matching controller.
- One natural sub-module: top2_tracker (best/second/best_idx registers plus the compare-update logic), keeping the FSM and ratio test in the top.

## Test plan
- Stream distances 300,120,450,130 (idx 0-3, last on idx 3) -> match_idx=1, match_dist=120, second_dist=130, match_ok=0 (600 ≥ 520).
- Stream 500,100,400 -> match_idx=1, match_dist=100, second_dist=400, match_ok=1 (500<1600); match_valid exactly 2 cycles after last accept.
- Ties: 200,200 -> match_idx=0, second_dist=200, match_ok=0.
- Single candidate 50 with dist_last -> match_dist=50, second_dist=16383, match_ok=1.
- Backpressure: hold match_ready=0 for 10 cycles -> match_valid and outputs stable; start pulses and dist_valid during DONE ignored; release -> IDLE next cycle.
- Assert rst_n=0 mid-SCAN after 5 candidates -> outputs return to reset values immediately; new query of 700,10 -> match_idx=1, match_ok=1, no residue from aborted query.
